// File: rtl/crumb_collector.sv
// crumb_collector
//   Downstream consumer of a crumb chain. It samples the chain's random bit
//   whenever the chain's toggled clock output changes level. The samples are
//   packed MSB-first into bytes, and each byte is queued in a small
//   first-word-fall-through FIFO that drains over a valid/ready handshake.
//
//   Optional feature macro: CRUMB_VN_DEBIAS_EN
//     When defined, von Neumann debiasing runs on the accepted samples
//     before packing. Pair 01 yields 0, pair 10 yields 1, and 00/11 yield
//     nothing.
//
// Parameters
//   DEPTH       FIFO depth in bytes (power of two, >= 2)
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active low
//   en          collector enable (gates sampling only)
//   crumb_clk   toggled clock of the last crumb stage, treated as data
//   crumb_en    enable output of the last crumb stage
//   crumb_bit   random bit of the last crumb stage
//   data_o      FIFO head byte, meaningful while valid_o is high
//   valid_o     FIFO non-empty
//   ready_i     consumer accepts data_o
//   fill_o      number of bytes currently held
//   overflow_o  sticky: a completed byte was dropped on a full FIFO

module crumb_collector #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       crumb_clk,
    input  logic                       crumb_en,
    input  logic                       crumb_bit,
    output logic [7:0]                 data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     fill_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic          crumb_clk_q;
    logic          strobe;
    logic          bit_valid;
    logic          bit_val;
    logic [7:0]    sr;
    logic [2:0]    bit_cnt;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          do_write;
    logic [7:0]    push_byte;

    // The previous level of crumb_clk is tracked even while disabled.
    // Because of this, re-enabling never sees a stale level difference.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crumb_clk_q <= 1'b0;
        end else begin
            crumb_clk_q <= crumb_clk;
        end
    end

    // Either toggle direction of crumb_clk counts as a new sample.
    assign strobe = (crumb_clk != crumb_clk_q) && crumb_en && en;

`ifdef CRUMB_VN_DEBIAS_EN
    logic pair_have;
    logic pair_a;

    // Accepted samples are grouped into pairs. The first sample of a pair is
    // stored. The second sample closes the pair. An unequal pair yields the
    // first sample of the pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_have <= 1'b0;
            pair_a    <= 1'b0;
        end else if (strobe) begin
            if (!pair_have) begin
                pair_have <= 1'b1;
                pair_a    <= crumb_bit;
            end else begin
                pair_have <= 1'b0;
            end
        end
    end

    assign bit_valid = strobe && pair_have && (pair_a != crumb_bit);
    assign bit_val   = pair_a;
`else
    assign bit_valid = strobe;
    assign bit_val   = crumb_bit;
`endif

    // The packed byte includes the bit arriving this cycle. The push happens
    // on the same edge that accepts the eighth bit.
    assign push_byte = {sr[6:0], bit_val};
    assign push      = bit_valid && (bit_cnt == 3'd7);

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign valid_o  = !empty;
    assign pop      = valid_o && ready_i;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign do_write = push && (!full || pop);
    assign fill_o   = wr_ptr - rd_ptr;
    assign data_o   = mem[rd_ptr[AW-1:0]];

    // Shift register and bit counter. The counter wraps naturally after the
    // eighth bit. Older bits left in sr are shifted out by the next byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr      <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (bit_valid) begin
            sr      <= push_byte;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // FIFO storage, pointers and the sticky overflow flag. The storage is
    // cleared so that data_o reads 8'h00 straight out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (do_write) begin
                mem[wr_ptr[AW-1:0]] <= push_byte;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !do_write) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crumb_collector.sv
// tb_crumb_collector
//   Directed testbench for crumb_collector with DEPTH=4. Inputs change 1 ns
//   after each rising edge. Outputs are checked at that same point, once the
//   registered state has settled.

module tb_crumb_collector;

    localparam int DEPTH = 4;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          crumb_clk;
    logic          crumb_en;
    logic          crumb_bit;
    logic [7:0]    data_o;
    logic          valid_o;
    logic          ready_i;
    logic [FW-1:0] fill_o;
    logic          overflow_o;

    int applied;
    int miscompares;

    typedef struct {
        logic [7:0] byte_in;
        logic       ready_last;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic [7:0] exp_fill;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[6];

    crumb_collector #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .crumb_clk  (crumb_clk),
        .crumb_en   (crumb_en),
        .crumb_bit  (crumb_bit),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .fill_o     (fill_o),
        .overflow_o (overflow_o)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one value and report a miss.
    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Toggle crumb_clk with a new bit so the next edge samples it.
    task automatic sendBit(input logic b);
        crumb_clk = ~crumb_clk;
        crumb_bit = b;
        tick();
    endtask

    // Send one byte MSB first. ready_i is applied only on the eighth bit.
    task automatic applyStimulus(input logic [7:0] b, input logic ready_last);
        for (int i = 7; i >= 0; i--) begin
            ready_i = (i == 0) ? ready_last : 1'b0;
            sendBit(b[i]);
        end
        ready_i = 1'b0;
    endtask

    // Reset with crumb_clk parked low to match the cleared crumb_clk_q.
    task automatic doReset();
        rst_n     = 1'b0;
        crumb_clk = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic checkState(input string tag, input logic [7:0] d, input logic v,
                              input logic [7:0] f, input logic o);
        checkOutput({tag, ".data"}, data_o, d);
        checkOutput({tag, ".valid"}, 8'(valid_o), 8'(v));
        checkOutput({tag, ".fill"}, 8'(fill_o), f);
        checkOutput({tag, ".ovf"}, 8'(overflow_o), 8'(o));
    endtask

    // Drain bytes one per cycle, checking each head before it is popped.
    task automatic drain(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] exp [4];
        exp[0] = b0; exp[1] = b1; exp[2] = b2; exp[3] = b3;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput({tag, ".head"}, data_o, exp[i]);
            checkOutput({tag, ".hvalid"}, 8'(valid_o), 8'd1);
            tick();
        end
        ready_i = 1'b0;
        checkOutput({tag, ".empty_valid"}, 8'(valid_o), 8'd0);
        checkOutput({tag, ".empty_fill"}, 8'(fill_o), 8'd0);
    endtask

    initial begin
        applied     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        en          = 1'b1;
        crumb_en    = 1'b1;
        crumb_clk   = 1'b0;
        crumb_bit   = 1'b0;
        ready_i     = 1'b0;
        #1;
        tick();
        doReset();
        checkState("reset", 8'h00, 1'b0, 8'd0, 1'b0);

`ifdef CRUMB_VN_DEBIAS_EN
        begin
            logic [19:0] raw;
            raw = 20'b10_01_00_11_10_10_01_01_10_01;
            for (int i = 19; i >= 0; i--) begin
                sendBit(raw[i]);
                if (i == 1) checkOutput("debias.pre_fill", 8'(fill_o), 8'd0);
            end
            checkState("debias", 8'hB2, 1'b1, 8'd1, 1'b0);
        end
`else
        // Fill to full, then do a push and pop together on a full FIFO twice.
        vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b1, 8'd1, 1'b0};
        vecs[1] = '{8'h11, 1'b0, 8'hA5, 1'b1, 8'd2, 1'b0};
        vecs[2] = '{8'h22, 1'b0, 8'hA5, 1'b1, 8'd3, 1'b0};
        vecs[3] = '{8'h33, 1'b0, 8'hA5, 1'b1, 8'd4, 1'b0};
        vecs[4] = '{8'h44, 1'b1, 8'h11, 1'b1, 8'd4, 1'b0};
        vecs[5] = '{8'h66, 1'b1, 8'h22, 1'b1, 8'd4, 1'b0};
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].byte_in, vecs[v].ready_last);
            checkState($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_valid,
                       vecs[v].exp_fill, vecs[v].exp_ovf);
        end
        drain("fulldrain", 8'h22, 8'h33, 8'h44, 8'h66);

        // Gating: hold crumb_clk, then toggle with en low, then with crumb_en low.
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        for (int i = 0; i < 20; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) sendBit(1'b1);
        en = 1'b1;
        tick();
        crumb_en = 1'b0;
        for (int i = 0; i < 10; i++) sendBit(1'b1);
        crumb_en = 1'b1;
        tick();
        sendBit(1'b0); sendBit(1'b1); sendBit(1'b0); sendBit(1'b0);
        checkOutput("gate.seven_bits_fill", 8'(fill_o), 8'd0);
        sendBit(1'b1);
        checkState("gate", 8'hA9, 1'b1, 8'd1, 1'b0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        checkOutput("gate.pop_fill", 8'(fill_o), 8'd0);

        // Overflow: five bytes into a four-deep FIFO with no reader.
        for (int b = 1; b <= 5; b++) applyStimulus(8'(b), 1'b0);
        checkState("ovf", 8'h01, 1'b1, 8'd4, 1'b1);
        drain("ovfdrain", 8'h01, 8'h02, 8'h03, 8'h04);
        checkOutput("ovf.sticky", 8'(overflow_o), 8'd1);

        // Reset mid-byte discards the partial byte and the overflow flag.
        for (int i = 0; i < 5; i++) sendBit(1'b1);
        doReset();
        checkState("midreset", 8'h00, 1'b0, 8'd0, 1'b0);
        applyStimulus(8'h3C, 1'b0);
        checkState("after_reset", 8'h3C, 1'b1, 8'd1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
